// File: rtl/ring_noc_pkg.sv
// ring_noc_pkg: shared definitions for the ring NoC router.
//   - Packet field offsets: [48] valid, [47:32] timestamp, [31:16] source,
//     [15:0] destination.
//   - Input port indices (east, west, local).
//   - Route direction encoding. Its values double as output indices:
//     0 = east link, 1 = west link, 2 = eject.
//   - route_dir(): shortest-path ring route for one head packet.
package ring_noc_pkg;

    localparam int unsigned VALID_BIT = 48;
    localparam int unsigned TS_MSB    = 47;
    localparam int unsigned TS_LSB    = 32;
    localparam int unsigned SRC_MSB   = 31;
    localparam int unsigned SRC_LSB   = 16;
    localparam int unsigned DST_MSB   = 15;
    localparam int unsigned DST_LSB   = 0;

    localparam int unsigned PORT_EAST  = 0;
    localparam int unsigned PORT_WEST  = 1;
    localparam int unsigned PORT_LOCAL = 2;
    localparam int unsigned NUM_PORTS  = 3;

    typedef enum logic [1:0] {
        DIR_EAST  = 2'd0,
        DIR_WEST  = 2'd1,
        DIR_EJECT = 2'd2
    } dir_e;

    // Out-of-range destinations go to eject so they leave the ring here;
    // the router counts them as drops. A tie at exactly half the ring goes east.
    function automatic dir_e route_dir(input logic [15:0] dst,
                                       input int unsigned num_nodes,
                                       input int unsigned router_id);
        int unsigned d;
        if (32'(dst) >= num_nodes || 32'(dst) == router_id) begin
            return DIR_EJECT;
        end
        d = (32'(dst) + num_nodes - router_id) % num_nodes;
        return (d <= num_nodes / 2) ? DIR_EAST : DIR_WEST;
    endfunction

endpackage

// File: rtl/router_input_fifo.sv
// router_input_fifo: synchronous FIFO used for each router input.
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data. A write is ignored when the FIFO is
//                full, unless a pop happens on the same edge.
//   pop, dout  : read request and head data (dout is valid while !empty)
//   full, empty, free_count : occupancy status
module router_input_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 49
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign free_count = (AW+1)'(DEPTH) - count;
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reset clears count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ring_router_vc.sv
// ring_router_vc: bidirectional ring router node with per-input FIFOs.
//   clk, rst, clk_counter       : clock, synchronous active-high reset,
//                                 global cycle count used for age and latency
//   link_east_in / link_west_in : packets from the neighbours (valid bit qualifies)
//   local_in / local_in_ready   : injection port; accepted when valid & ready
//   backpressure_*_rd           : neighbour stalls; block sends in that direction
//   link_east_out/link_west_out : registered link outputs, all-zero when idle
//   backpressure_*_wr           : registered stalls to neighbours
//   eject_out                   : registered packet delivered to this node
//   total_packet_recieve, total_latency, total_drop : ejection statistics
module ring_router_vc
    import ring_noc_pkg::*;
#(
    parameter int unsigned NUM_NODES        = 8,
    parameter int unsigned ROUTER_ID        = 0,
    parameter int unsigned PACKET_SIZE      = 49,
    parameter int unsigned BUFFER_SIZE      = 4,
    parameter int unsigned BUFFER_THRESHOLD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            clk_counter,
    input  logic [PACKET_SIZE-1:0] link_east_in,
    input  logic [PACKET_SIZE-1:0] link_west_in,
    input  logic [PACKET_SIZE-1:0] local_in,
    output logic                   local_in_ready,
    input  logic                   backpressure_east_rd,
    input  logic                   backpressure_west_rd,
    output logic [PACKET_SIZE-1:0] link_east_out,
    output logic [PACKET_SIZE-1:0] link_west_out,
    output logic                   backpressure_east_wr,
    output logic                   backpressure_west_wr,
    output logic [PACKET_SIZE-1:0] eject_out,
    output logic [63:0]            total_packet_recieve,
    output logic [63:0]            total_latency,
    output logic [31:0]            total_drop
);
    localparam int unsigned FW = $clog2(BUFFER_SIZE) + 1;

    if (BUFFER_THRESHOLD < 1 || BUFFER_THRESHOLD >= BUFFER_SIZE) begin : g_bad_threshold
        $error("ring_router_vc: BUFFER_THRESHOLD must be in 1..BUFFER_SIZE-1");
    end
    if (BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_size
        $error("ring_router_vc: BUFFER_SIZE must be a power of 2 and >= 2");
    end

    logic [PACKET_SIZE-1:0] in_pkt [NUM_PORTS];
    logic [PACKET_SIZE-1:0] head   [NUM_PORTS];
    logic [FW-1:0]          free   [NUM_PORTS];
    logic [FW-1:0]          free_next [NUM_PORTS];
    dir_e                   dir    [NUM_PORTS];
    logic [15:0]            age    [NUM_PORTS];
    logic [NUM_PORTS-1:0]   push, pop, full, empty, drop;
    logic [NUM_PORTS-1:0]   blocked;

    assign local_in_ready = !full[PORT_LOCAL];
    assign blocked        = {1'b0, backpressure_west_rd, backpressure_east_rd};

    always_comb begin
        in_pkt[PORT_EAST]  = link_east_in;
        in_pkt[PORT_WEST]  = link_west_in;
        in_pkt[PORT_LOCAL] = local_in;
        push = '0;
        drop = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            // A full link FIFO still accepts a packet when its head leaves on the same edge.
            if (p == PORT_LOCAL) begin
                push[p] = in_pkt[p][VALID_BIT] && !full[p];
            end else begin
                push[p] = in_pkt[p][VALID_BIT] && (!full[p] || pop[p]);
                drop[p] = in_pkt[p][VALID_BIT] && full[p] && !pop[p];
            end
            dir[p]       = route_dir(head[p][DST_MSB:DST_LSB], NUM_NODES, ROUTER_ID);
            age[p]       = clk_counter - head[p][TS_MSB:TS_LSB];
            free_next[p] = free[p] + FW'(pop[p]) - FW'(push[p]);
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
        router_input_fifo #(.DEPTH(BUFFER_SIZE), .WIDTH(PACKET_SIZE)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (push[p]),
            .pop        (pop[p]),
            .din        (in_pkt[p]),
            .dout       (head[p]),
            .full       (full[p]),
            .empty      (empty[p]),
            .free_count (free[p])
        );
    end

    // One oldest-first arbiter per output. The scan starts at the round-robin
    // pointer and uses a strict '>' comparison, so among equal ages the first
    // requester in round-robin order wins.
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        logic [NUM_PORTS-1:0]   req;
        logic                   win_valid;
        logic [1:0]             win_idx;
        logic [1:0]             rr_ptr;
        logic [PACKET_SIZE-1:0] win_pkt;

        always_comb begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                req[p] = !empty[p] && (dir[p] == dir_e'(o)) && !blocked[o];
            end
        end

        always_comb begin
            logic [15:0] best_age;
            int unsigned idx;
            win_valid = 1'b0;
            win_idx   = rr_ptr;
            best_age  = '0;
            idx       = 0;
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_PORTS;
                if (req[idx] && (!win_valid || age[idx] > best_age)) begin
                    win_valid = 1'b1;
                    win_idx   = 2'(idx);
                    best_age  = age[idx];
                end
            end
        end

        assign win_pkt = head[win_idx];

        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr <= 2'(PORT_EAST);
            end else if (win_valid) begin
                rr_ptr <= (win_idx == 2'(NUM_PORTS - 1)) ? 2'd0 : win_idx + 2'd1;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (g_arb[PORT_EAST].win_valid)  pop[g_arb[PORT_EAST].win_idx]  = 1'b1;
        if (g_arb[PORT_WEST].win_valid)  pop[g_arb[PORT_WEST].win_idx]  = 1'b1;
        if (g_arb[PORT_LOCAL].win_valid) pop[g_arb[PORT_LOCAL].win_idx] = 1'b1;
    end

    logic [PACKET_SIZE-1:0] ej_pkt;
    logic                   ej_bad, ej_ok;
    logic [15:0]            ej_age;
    logic [1:0]             drop_inc;
    logic [32:0]            drop_sum;

    assign ej_pkt   = g_arb[DIR_EJECT].win_pkt;
    assign ej_bad   = 32'(ej_pkt[DST_MSB:DST_LSB]) >= NUM_NODES;
    assign ej_ok    = g_arb[DIR_EJECT].win_valid && !ej_bad;
    assign ej_age   = clk_counter - ej_pkt[TS_MSB:TS_LSB];
    assign drop_inc = 2'(drop[PORT_EAST]) + 2'(drop[PORT_WEST])
                    + 2'(g_arb[DIR_EJECT].win_valid && ej_bad);
    assign drop_sum = {1'b0, total_drop} + 33'(drop_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            link_east_out        <= '0;
            link_west_out        <= '0;
            eject_out            <= '0;
            backpressure_east_wr <= 1'b0;
            backpressure_west_wr <= 1'b0;
            total_packet_recieve <= '0;
            total_latency        <= '0;
            total_drop           <= '0;
        end else begin
            link_east_out <= g_arb[DIR_EAST].win_valid ? g_arb[DIR_EAST].win_pkt : '0;
            link_west_out <= g_arb[DIR_WEST].win_valid ? g_arb[DIR_WEST].win_pkt : '0;
            eject_out     <= ej_ok ? ej_pkt : '0;
            backpressure_east_wr <= free_next[PORT_EAST] <= FW'(BUFFER_THRESHOLD);
            backpressure_west_wr <= free_next[PORT_WEST] <= FW'(BUFFER_THRESHOLD);
            if (ej_ok) begin
                total_packet_recieve <= total_packet_recieve + 64'd1;
                total_latency        <= total_latency + 64'(ej_age);
            end
            total_drop <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

endmodule
